mem_lsu: RTL and testbench

Load/store initiator that drives the single-port word-addressed data memory on behalf of the ARM core datapath.
- Accepts one byte, halfword or word access per request over a valid/ready handshake.
- Issues word-aligned memory cycles; sub-word stores are done as read-modify-write because memory has only a whole-word write enable.
- Returns zero- or sign-extended load data with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_lane.sv | 24 ++
 rtl/mem_lsu.sv | 107 ++++++++++
 tb/tb_mem_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, lane masks and size decode for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  localparam logic [31:0] WORD_MASK = 32'hffff_ffff;
  function automatic size_e decode_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : size_e'(s);
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational little-endian lane extract (load) and merge (store).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  size_e       size_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [15:0] lane;
  always_comb begin
    sh      = (size_i == SZ_BYTE) ? {lo_i, 3'b000} : (size_i == SZ_HALF) ? {lo_i[1], 4'b0000} : 5'd0;
    mask    = (size_i == SZ_BYTE) ? BYTE_MASK : (size_i == SZ_HALF) ? HALF_MASK : WORD_MASK;
    lane    = 16'(word_i >> sh);
    ext_o   = (size_i == SZ_BYTE) ? {{24{sgn_i & lane[7]}}, lane[7:0]} :
              (size_i == SZ_HALF) ? {{16{sgn_i & lane[15]}}, lane} : word_i;
    merge_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for a word-wide single-port memory; sub-word stores use read-modify-write.
// Optional LSU_ALIGN_CHECK_EN: misaligned halfword/word requests answer with resp_err and no memory cycle.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  state_e            state_q;
  size_e             size_q;
  size_e             req_sz;
  logic              we_q, sgn_q, mis;
  logic [1:0]        lo_q;
  logic [DATA_W-1:0] wdata_q, ext, merged;

  assign req_sz    = decode_size(req_size);
  assign req_ready = (state_q == IDLE);
`ifdef LSU_ALIGN_CHECK_EN
  assign mis = (req_sz == SZ_HALF && req_addr[0]) || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  lsu_lane u_lane (
    .word_i  (mem_rd),
    .lo_i    (lo_q),
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .wdata_i (wdata_q),
    .ext_o   (ext),
    .merge_o (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      size_q     <= SZ_BYTE;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      lo_q       <= 2'b00;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          mem_a      <= {req_addr[ADDR_W-1:2], 2'b00};
          mem_wd     <= req_wdata;
          size_q     <= req_sz;
          we_q       <= req_we;
          sgn_q      <= req_signed;
          lo_q       <= req_addr[1:0];
          wdata_q    <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= mis;
          if (mis) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
          end else if (req_we && req_sz == SZ_WORD) begin
            state_q <= WR;
            mem_we  <= 1'b1;
          end else begin
            state_q <= RD;
          end
        end
        // RD samples mem_rd: either the load result or the word to merge into
        RD: if (we_q) begin
          mem_wd  <= merged;
          mem_we  <= 1'b1;
          state_q <= WR;
        end else begin
          resp_rdata <= ext;
          resp_valid <= 1'b1;
          state_q    <= RESP;
        end
        WR: begin
          resp_valid <= 1'b1;
          state_q    <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a byte-level reference memory.
module tb_mem_lsu;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          we_cnt = 0;
  logic [31:0] we_a = '0, we_d = '0;
  logic [31:0] got_rd, exp_rd;
  logic        got_err, exp_err;
  int          got_lat, exp_lat, got_pul, exp_pul;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[5:2]];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_a[5:2]] <= mem_wd;
      we_cnt <= we_cnt + 1;
      we_a   <= mem_a;
      we_d   <= mem_wd;
    end
  end

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (int'(a) * 8)) & 32'hff;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (int'(a[1]) * 16)) & 32'hffff;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic [31:0] d);
    logic [31:0] r;
    int first, nb;
    if (sz >= 2'd2) return d;
    nb    = (sz == 2'd0) ? 1 : 2;
    first = (sz == 2'd0) ? int'(a) : int'(a[1]) * 2;
    r = w;
    for (int k = 0; k < 4; k++)
      if (k >= first && k < first + nb) r[8*k +: 8] = d[8*(k-first) +: 8];
    return r;
  endfunction

  function automatic logic ref_mis(logic [1:0] sz, logic [1:0] a);
`ifdef LSU_ALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Issues one request, fills got_* from the DUT and exp_* from the reference model.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    int guard, w0, idx;
    guard = 0;
    while (!req_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    idx = int'(a[5:2]);
    exp_err = ref_mis(sz, a[1:0]);
    exp_rd  = '0;
    exp_pul = 0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin exp_lat = 2; exp_rd = ref_load(ref_mem[idx], a[1:0], sz, sg); end
    else begin
      exp_lat = (sz >= 2'd2) ? 2 : 3;
      exp_pul = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], a[1:0], sz, d);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got_lat = 1;
    while (!resp_valid && got_lat < 8) begin @(posedge clk); #1; got_lat++; end
    got_rd = resp_rdata; got_err = resp_err; got_pul = we_cnt - w0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    n_chk += 6;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", mem_wd); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store_load();
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hdeadbeef);
    n_chk += 4;
    if (got_pul !== 1) begin n_fail++; $display("FAIL wst_pulses: got %0d want 1", got_pul); end
    if (we_a !== 32'h8) begin n_fail++; $display("FAIL wst_mem_a: got %h want 00000008", we_a); end
    if (we_d !== 32'hdeadbeef) begin n_fail++; $display("FAIL wst_mem_wd: got %h want deadbeef", we_d); end
    if (got_lat !== 2) begin n_fail++; $display("FAIL wst_latency: got %0d want 2", got_lat); end
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    n_chk += 3;
    if (got_rd !== 32'hdeadbeef) begin n_fail++; $display("FAIL wld_rdata: got %h want deadbeef", got_rd); end
    if (got_lat !== 2) begin n_fail++; $display("FAIL wld_latency: got %0d want 2", got_lat); end
    if (got_pul !== 0) begin n_fail++; $display("FAIL wld_pulses: got %0d want 0", got_pul); end
  endtask

  task automatic test_byte_rmw();
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h000000aa);
    n_chk += 4;
    if (we_d !== 32'h11aa3344) begin n_fail++; $display("FAIL rmw_mem_wd: got %h want 11aa3344", we_d); end
    if (we_a !== 32'h4) begin n_fail++; $display("FAIL rmw_mem_a: got %h want 00000004", we_a); end
    if (got_lat !== 3) begin n_fail++; $display("FAIL rmw_latency: got %0d want 3", got_lat); end
    if (got_pul !== 1) begin n_fail++; $display("FAIL rmw_pulses: got %0d want 1", got_pul); end
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    n_chk++;
    if (got_rd !== 32'h11aa3344) begin n_fail++; $display("FAIL rmw_readback: got %h want 11aa3344", got_rd); end
  endtask

  task automatic test_signed_loads();
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h80ff7f01);
    do_req(1'b0, 2'd0, 1'b1, 32'h2, 32'h0);
    n_chk++;
    if (got_rd !== 32'hffffffff) begin n_fail++; $display("FAIL ldrsb: got %h want ffffffff", got_rd); end
    do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
    n_chk++;
    if (got_rd !== 32'h00000080) begin n_fail++; $display("FAIL ldrb: got %h want 00000080", got_rd); end
    do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    n_chk++;
    if (got_rd !== 32'hffff80ff) begin n_fail++; $display("FAIL ldrsh: got %h want ffff80ff", got_rd); end
  endtask

  task automatic test_misaligned();
    do_req(1'b0, 2'd2, 1'b0, 32'h5, 32'h0);
    n_chk += 4;
`ifdef LSU_ALIGN_CHECK_EN
    if (got_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", got_err); end
    if (got_rd !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", got_rd); end
    if (got_lat !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d want 1", got_lat); end
`else
    if (got_err !== 1'b0) begin n_fail++; $display("FAIL mis_err: got %b want 0", got_err); end
    if (got_rd !== 32'h11aa3344) begin n_fail++; $display("FAIL mis_rdata: got %h want 11aa3344", got_rd); end
    if (got_lat !== 2) begin n_fail++; $display("FAIL mis_latency: got %0d want 2", got_lat); end
`endif
    if (got_pul !== 0) begin n_fail++; $display("FAIL mis_pulses: got %0d want 0", got_pul); end
  endtask

  task automatic test_back_to_back();
    int acc, rsp, dbl;
    logic prev;
    acc = 0; rsp = 0; dbl = 0; prev = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h8;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc++;
      @(posedge clk); #1;
      if (resp_valid) begin
        rsp++;
        if (prev) dbl++;
        n_chk++;
        if (resp_rdata !== ref_mem[2]) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", resp_rdata, ref_mem[2]); end
      end
      prev = resp_valid;
    end
    req_valid = 1'b0;
    n_chk += 3;
    if (acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", acc); end
    if (rsp !== 4) begin n_fail++; $display("FAIL b2b_responses: got %0d want 4", rsp); end
    if (dbl !== 0) begin n_fail++; $display("FAIL b2b_double_resp: got %0d want 0", dbl); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0, rv;
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h9; req_wdata = 32'h55;
    w0 = we_cnt; rv = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_we: got %b want 0", mem_we); end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) rv++;
      @(posedge clk); #1;
    end
    n_chk += 2;
    if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d want 0", we_cnt - w0); end
    if (rv !== 0) begin n_fail++; $display("FAIL rstmid_resp: got %0d want 0", rv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
      n_chk += 4;
      if (got_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, got_rd, exp_rd); end
      if (got_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, got_err, exp_err); end
      if (got_lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, got_lat, exp_lat); end
      if (got_pul !== exp_pul) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %0d want %0d", i, got_pul, exp_pul); end
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rnd_memword[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_signed_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
